// File: rtl/osd_flip_pkg.sv
// Shared definitions for the OSD flip-candidate streamer.
//   ORD_W      : width of order fields (orders 0..3)
//   state_t    : streamer FSM encoding (IDLE / RUN / FIN)
//   binom      : binomial coefficient C(n,k), for elaboration-time sizing
//   cand_total : number of candidates for a given K, max order and zero-pattern option
package osd_flip_pkg;

    localparam int ORD_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic longint binom(input int n, input int k);
        longint r;
        r = 1;
        if (k < 0 || k > n) return 0;
        // Multiply before dividing so every intermediate stays an exact integer.
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    function automatic longint cand_total(input int k, input int ord, input bit include_zero);
        longint sum;
        sum = 0;
        for (int w = (include_zero ? 0 : 1); w <= ord; w++) sum = sum + binom(k, w);
        return sum;
    endfunction

endpackage

// File: rtl/osd_flip_candidate_streamer_if.sv
// Candidate stream handshake between the flip streamer and its consumer.
//   cand_valid / cand_ready : valid/ready handshake, transfer = valid & ready
//   cand_data               : MRI with the flip pattern applied
//   cand_mask               : flip pattern, bit p set = position p flipped
//   cand_order              : number of flipped positions
//   cand_idx                : 0-based sequence number within the run
//   cand_last               : final candidate of the run
// master = candidate producer, slave = consumer.
interface osd_flip_candidate_streamer_if
    import osd_flip_pkg::*;
#(
    parameter int K     = 8,
    parameter int CNT_W = 32
);
    logic             cand_valid;
    logic             cand_ready;
    logic [K-1:0]     cand_data;
    logic [K-1:0]     cand_mask;
    logic [ORD_W-1:0] cand_order;
    logic [CNT_W-1:0] cand_idx;
    logic             cand_last;

    modport master (
        output cand_valid, cand_data, cand_mask, cand_order, cand_idx, cand_last,
        input  cand_ready
    );

    modport slave (
        input  cand_valid, cand_data, cand_mask, cand_order, cand_idx, cand_last,
        output cand_ready
    );
endinterface

// File: rtl/osd_comb_index_stepper.sv
// Walks all index tuples i0<i1<..<i(w-1) over K positions, order by order.
//   clk, rst_n : clock, async active-low reset
//   load       : restart at order first_w with tuple {0,1,..}
//   first_w    : starting order applied on load
//   ord        : highest order of this run (used for wrap_last)
//   step       : advance to the next tuple (ignored when load is high)
//   mask       : one-hot OR of the active indices of the current tuple
//   w          : current order
//   wrap_last  : current tuple is {K-w..K-1} with w == ord (final candidate)
module osd_comb_index_stepper
    import osd_flip_pkg::*;
#(
    parameter int K         = 8,
    parameter int MAX_ORDER = 2
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [ORD_W-1:0] first_w,
    input  logic [ORD_W-1:0] ord,
    input  logic             step,
    output logic [K-1:0]     mask,
    output logic [ORD_W-1:0] w,
    output logic             wrap_last
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [K-1:0] ONE = K'(1);

    logic [MAX_ORDER-1:0][IW-1:0] idx;
    logic [MAX_ORDER-1:0][IW-1:0] nxt_idx;
    logic [ORD_W-1:0]             nxt_w;
    logic                         found;
    int                           piv;
    int                           base;

    // Next lexicographic tuple: bump the rightmost index that still has room
    // (idx[j] < K-w+j) and repack everything to its right contiguously.
    // With no such index the order is exhausted and w+1 starts at {0,1,..,w}.
    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        nxt_idx = idx;
        nxt_w   = w;
        found   = 1'b0;
        piv     = 0;
        base    = 0;
        for (int j = 0; j < MAX_ORDER; j++) begin
            if (j < int'(w) && int'(idx[j]) < K - int'(w) + j) begin
                found = 1'b1;
                piv   = j;
                base  = int'(idx[j]);
            end
        end
        if (found) begin
            for (int m = 0; m < MAX_ORDER; m++) begin
                if (m >= piv) nxt_idx[m] = IW'(base + 1 + m - piv);
            end
        end else begin
            nxt_w = w + ORD_W'(1);
            for (int m = 0; m < MAX_ORDER; m++) nxt_idx[m] = IW'(m);
        end
    end

    always_comb begin
        mask = '0;
        for (int j = 0; j < MAX_ORDER; j++) begin
            if (j < int'(w)) mask = mask | (ONE << idx[j]);
        end
    end

    // Final tuple of the top order: every active index sits at its maximum.
    always_comb begin
        wrap_last = (w == ord);
        for (int j = 0; j < MAX_ORDER; j++) begin
            if (j < int'(w) && int'(idx[j]) != K - int'(w) + j) wrap_last = 1'b0;
        end
    end

    // NOTE: the index registers are plain state, not a memory, so they take the
    // async reset like every other flop; load overwrites them before first use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            w   <= '0;
        end else if (load) begin
            for (int m = 0; m < MAX_ORDER; m++) idx[m] <= IW'(m);
            w <= first_w;
        end else if (step) begin
            idx <= nxt_idx;
            w   <= nxt_w;
        end
    end

endmodule

// File: rtl/osd_flip_candidate_streamer.sv
// OSD flipping stage: streams MRI ^ mask for every flip pattern of weight
// (INCLUDE_ZERO ? 0 : 1) .. clamp(order_sel), ascending by order, tuples in
// lexicographic order, over a valid/ready handshake.
//   clk, rst_n  : clock, async active-low reset
//   start       : launch / restart; latches mri and clamped order_sel
//   order_sel   : requested max order (clamped to MAX_ORDER)
//   mri         : MRI hard decisions
//   busy        : enumeration in progress (RUN)
//   cand        : candidate stream (master side)
//   done        : one-cycle pulse after the last transfer
//   total_count : transfers completed in the current / last run
module osd_flip_candidate_streamer
    import osd_flip_pkg::*;
#(
    parameter int K            = 8,
    parameter int MAX_ORDER    = 2,
    parameter int INCLUDE_ZERO = 1,
    parameter int CNT_W        = 32
)
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [ORD_W-1:0]                     order_sel,
    input  logic [K-1:0]                         mri,
    output logic                                 busy,
    osd_flip_candidate_streamer_if.master        cand,
    output logic                                 done,
    output logic [CNT_W-1:0]                     total_count
);
    if (MAX_ORDER < 1 || MAX_ORDER > 3) begin : g_bad_order
        $error("MAX_ORDER must be in 1..3");
    end
    if (K < MAX_ORDER) begin : g_bad_k
        $error("K must be >= MAX_ORDER");
    end
    if (CNT_W < 63 && cand_total(K, MAX_ORDER, INCLUDE_ZERO != 0) >= (longint'(1) << CNT_W)) begin : g_bad_cnt
        $error("CNT_W too narrow for the candidate count");
    end

    localparam logic [ORD_W-1:0] FIRST_W = ORD_W'((INCLUDE_ZERO != 0) ? 0 : 1);

    state_t           state;
    logic [K-1:0]     lat_mri;
    logic [ORD_W-1:0] lat_ord;
    logic [ORD_W-1:0] eff_ord;
    logic             valid_q;
    logic [CNT_W-1:0] idx_q;
    logic [K-1:0]     step_mask;
    logic [ORD_W-1:0] step_w;
    logic             wrap_last;
    logic             xfer;
    logic             empty_run;
    logic             step_en;

    assign eff_ord   = (int'(order_sel) > MAX_ORDER) ? ORD_W'(MAX_ORDER) : order_sel;
    assign empty_run = (eff_ord == '0) && (INCLUDE_ZERO == 0);
    assign xfer      = valid_q & cand.cand_ready;
    // A restart in the same cycle as a transfer wins; the stepper reloads instead.
    assign step_en   = xfer & ~wrap_last & ~start;

    osd_comb_index_stepper #(
        .K         (K),
        .MAX_ORDER (MAX_ORDER)
    ) u_stepper (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start),
        .first_w   (FIRST_W),
        .ord       (lat_ord),
        .step      (step_en),
        .mask      (step_mask),
        .w         (step_w),
        .wrap_last (wrap_last)
    );

    // Candidate fields come straight from the stepper registers; gating with
    // valid keeps them at zero outside a run (including reset).
    assign busy            = (state == RUN);
    assign cand.cand_valid = valid_q;
    assign cand.cand_data  = valid_q ? (lat_mri ^ step_mask) : '0;
    assign cand.cand_mask  = valid_q ? step_mask : '0;
    assign cand.cand_order = valid_q ? step_w : '0;
    assign cand.cand_last  = valid_q & wrap_last;
    assign cand.cand_idx   = idx_q;

    // NOTE: sequential state uses non-blocking assignments only; done is
    // defaulted low each cycle and a later assignment in the block overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lat_mri     <= '0;
            lat_ord     <= '0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            done        <= 1'b0;
            total_count <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                lat_mri     <= mri;
                lat_ord     <= eff_ord;
                idx_q       <= '0;
                total_count <= '0;
                if (empty_run) begin
                    state   <= FIN;
                    valid_q <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    state   <= RUN;
                    valid_q <= 1'b1;
                end
            end else begin
                unique case (state)
                    RUN: begin
                        if (xfer) begin
                            total_count <= total_count + CNT_W'(1);
                            if (wrap_last) begin
                                state   <= FIN;
                                valid_q <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                idx_q <= idx_q + CNT_W'(1);
                            end
                        end
                    end
                    FIN:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_osd_flip_candidate_streamer.sv
// Self-checking bench for osd_flip_candidate_streamer.
// dut_a: K=8, MAX_ORDER=2, INCLUDE_ZERO=1; dut_b: K=8, MAX_ORDER=3, INCLUDE_ZERO=0.
module tb_osd_flip_candidate_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b, ready, sel;
    logic [1:0] order_sel;
    logic [7:0] mri;
    logic       busy_a, busy_b, done_a, done_b;
    logic [31:0] total_a, total_b;

    osd_flip_candidate_streamer_if #(.K(8), .CNT_W(32)) if_a ();
    osd_flip_candidate_streamer_if #(.K(8), .CNT_W(32)) if_b ();
    assign if_a.cand_ready = ready;
    assign if_b.cand_ready = ready;

    osd_flip_candidate_streamer #(.K(8), .MAX_ORDER(2), .INCLUDE_ZERO(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .order_sel(order_sel), .mri(mri),
        .busy(busy_a), .cand(if_a), .done(done_a), .total_count(total_a)
    );
    osd_flip_candidate_streamer #(.K(8), .MAX_ORDER(3), .INCLUDE_ZERO(0), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .order_sel(order_sel), .mri(mri),
        .busy(busy_b), .cand(if_b), .done(done_b), .total_count(total_b)
    );

    // Monitor view of whichever DUT is under test.
    logic        m_valid, m_last, m_done, m_busy;
    logic [7:0]  m_data, m_mask;
    logic [1:0]  m_order;
    logic [31:0] m_idx, m_total;
    always_comb begin
        if (sel) begin
            m_valid = if_b.cand_valid; m_last = if_b.cand_last; m_done = done_b; m_busy = busy_b;
            m_data = if_b.cand_data; m_mask = if_b.cand_mask; m_order = if_b.cand_order;
            m_idx = if_b.cand_idx; m_total = total_b;
        end else begin
            m_valid = if_a.cand_valid; m_last = if_a.cand_last; m_done = done_a; m_busy = busy_a;
            m_data = if_a.cand_data; m_mask = if_a.cand_mask; m_order = if_a.cand_order;
            m_idx = if_a.cand_idx; m_total = total_a;
        end
    end

    typedef struct {
        int         run;
        int         idx;
        logic [7:0] data;
        logic [7:0] mask;
        logic [1:0] order;
        logic       last;
    } vec_t;

    vec_t        tbl[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  got_data[$], got_mask[$];
    logic [1:0]  got_order[$];
    logic        got_last[$];
    logic [31:0] got_idx[$];
    logic [7:0]  exp_mask[$];
    int          last_cyc, done_cyc;
    logic [31:0] total_at_done;
    bit          saw_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input bit which, input logic [7:0] m, input logic [1:0] o);
        @(negedge clk);
        sel = which; mri = m; order_sel = o; ready = 1'b0;
        if (which) start_b = 1'b1; else start_a = 1'b1;
    endtask

    // Consume the stream until done (or the cycle budget runs out), checking
    // that a stalled candidate holds all its fields.
    task automatic collect(input int max_cycles, input bit rand_ready);
        bit          stall;
        logic [50:0] held, now_v;
        got_data.delete(); got_mask.delete(); got_order.delete(); got_last.delete(); got_idx.delete();
        saw_done = 1'b0; last_cyc = -1; done_cyc = -1; total_at_done = '0;
        stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < max_cycles && !saw_done; cyc++) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0; mri = 8'h3C; order_sel = 2'd1;
            now_v = {m_data, m_mask, m_order, m_last, m_idx};
            if (stall) check("stall_hold", 64'(now_v), 64'(held));
            if (m_done) begin
                saw_done = 1'b1; done_cyc = cyc; total_at_done = m_total;
            end
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && ready) begin
                got_data.push_back(m_data); got_mask.push_back(m_mask);
                got_order.push_back(m_order); got_last.push_back(m_last);
                got_idx.push_back(m_idx);
                if (m_last) last_cyc = cyc;
            end
            stall = m_valid && !ready;
            held  = now_v;
        end
        if (!saw_done) check("done_timeout", 64'd0, 64'd1);
    endtask

    // Reference enumeration built from nested loops over tuples.
    task automatic compare_run(input string name, input logic [7:0] m, input int ord, input bit iz);
        int n;
        exp_mask.delete();
        if (iz) exp_mask.push_back(8'h00);
        if (ord >= 1) for (int a = 0; a < 8; a++) exp_mask.push_back(8'(1 << a));
        if (ord >= 2)
            for (int a = 0; a < 8; a++)
                for (int b = a + 1; b < 8; b++) exp_mask.push_back(8'((1 << a) | (1 << b)));
        if (ord >= 3)
            for (int a = 0; a < 8; a++)
                for (int b = a + 1; b < 8; b++)
                    for (int c = b + 1; c < 8; c++)
                        exp_mask.push_back(8'((1 << a) | (1 << b) | (1 << c)));
        n = exp_mask.size();
        check({name, "_count"}, 64'(got_mask.size()), 64'(n));
        check({name, "_total"}, 64'(total_at_done), 64'(n));
        if (n > 0) check({name, "_done_lat"}, 64'(done_cyc), 64'(last_cyc + 1));
        for (int i = 0; i < n && i < got_mask.size(); i++)
            check({name, "_cand"},
                  64'({got_data[i], got_mask[i], got_order[i], got_last[i], got_idx[i]}),
                  64'({m ^ exp_mask[i], exp_mask[i], 2'($countones(exp_mask[i])), (i == n - 1), 32'(i)}));
    endtask

    task automatic apply_table(input int run);
        foreach (tbl[t]) begin
            if (tbl[t].run == run) begin
                if (tbl[t].idx < got_mask.size())
                    check($sformatf("tbl_run%0d_idx%0d", run, tbl[t].idx),
                          64'({got_data[tbl[t].idx], got_mask[tbl[t].idx], got_order[tbl[t].idx], got_last[tbl[t].idx]}),
                          64'({tbl[t].data, tbl[t].mask, tbl[t].order, tbl[t].last}));
                else
                    check($sformatf("tbl_run%0d_idx%0d_missing", run, tbl[t].idx), 64'd0, 64'd1);
            end
        end
    endtask

    task automatic after_done(input string name);
        check({name, "_at_done_idle"}, 64'({m_busy, m_valid}), 64'd0);
        @(negedge clk);
        check({name, "_done_pulse"}, 64'({m_done, m_busy, m_valid}), 64'd0);
    endtask

    initial begin
        // Hand-computed spot vectors: run 1 (mri A5, order 2, zero included),
        // run 3 (mri 5A, order 3, zero excluded).
        tbl.push_back('{1,  0, 8'hA5, 8'h00, 2'd0, 1'b0});
        tbl.push_back('{1,  1, 8'hA4, 8'h01, 2'd1, 1'b0});
        tbl.push_back('{1,  8, 8'h25, 8'h80, 2'd1, 1'b0});
        tbl.push_back('{1,  9, 8'hA6, 8'h03, 2'd2, 1'b0});
        tbl.push_back('{1, 15, 8'h24, 8'h81, 2'd2, 1'b0});
        tbl.push_back('{1, 16, 8'hA3, 8'h06, 2'd2, 1'b0});
        tbl.push_back('{1, 36, 8'h65, 8'hC0, 2'd2, 1'b1});
        tbl.push_back('{3,  0, 8'h5B, 8'h01, 2'd1, 1'b0});
        tbl.push_back('{3,  8, 8'h59, 8'h03, 2'd2, 1'b0});
        tbl.push_back('{3, 36, 8'h5D, 8'h07, 2'd3, 1'b0});
        tbl.push_back('{3, 91, 8'hBA, 8'hE0, 2'd2 + 2'd1, 1'b1});

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; ready = 1'b0; sel = 1'b0;
        order_sel = 2'd0; mri = 8'h00;
        #12;
        check("reset_a_ctl", 64'({if_a.cand_valid, busy_a, done_a, if_a.cand_last, if_a.cand_order, if_a.cand_data, if_a.cand_mask}), 64'd0);
        check("reset_a_cnt", 64'({if_a.cand_idx, total_a}), 64'd0);
        check("reset_b_ctl", 64'({if_b.cand_valid, busy_b, done_b, if_b.cand_data, if_b.cand_mask, total_b}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: full-rate run.
        launch(1'b0, 8'hA5, 2'd2);
        collect(200, 1'b0);
        compare_run("run1", 8'hA5, 2, 1'b1);
        check("run1_rate", 64'(last_cyc), 64'd36);
        apply_table(1);
        after_done("run1");

        // 2: same run under random back-pressure.
        launch(1'b0, 8'hA5, 2'd2);
        collect(600, 1'b1);
        compare_run("run2", 8'hA5, 2, 1'b1);
        after_done("run2");

        // 3: order 3, zero pattern excluded.
        launch(1'b1, 8'h5A, 2'd3);
        collect(300, 1'b0);
        compare_run("run3", 8'h5A, 3, 1'b0);
        apply_table(3);
        after_done("run3");

        // 4a: order_sel above MAX_ORDER clamps.
        launch(1'b0, 8'hA5, 2'd3);
        collect(200, 1'b0);
        compare_run("run4a", 8'hA5, 2, 1'b1);

        // 4b: empty run.
        launch(1'b1, 8'hA5, 2'd0);
        collect(20, 1'b0);
        compare_run("run4b", 8'hA5, 0, 1'b0);
        check("run4b_done_lat", 64'(done_cyc), 64'd0);
        after_done("run4b");

        // 5: restart at idx 10.
        launch(1'b0, 8'hA5, 2'd2);
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 50 && !hit; c++) begin
                @(negedge clk);
                start_a = 1'b0;
                if (m_valid && m_idx == 32'd10) begin
                    hit = 1'b1;
                    start_a = 1'b1; mri = 8'h0F; order_sel = 2'd2;
                end
                ready = 1'b1;
            end
            if (!hit) check("abort_idx10_timeout", 64'd0, 64'd1);
        end
        @(negedge clk);
        check("abort_restart", 64'({m_valid, m_done, m_data, m_idx, m_total}),
              64'({1'b1, 1'b0, 8'h0F, 32'd0, 32'd0}));
        start_a = 1'b0; ready = 1'b0;
        collect(200, 1'b0);
        compare_run("run5", 8'h0F, 2, 1'b1);

        // 6: asynchronous reset mid-run.
        launch(1'b0, 8'hA5, 2'd2);
        repeat (5) begin
            @(negedge clk);
            start_a = 1'b0; ready = 1'b1;
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_ctl", 64'({m_valid, m_busy, m_done, m_last, m_order, m_data, m_mask}), 64'd0);
        check("async_rst_cnt", 64'({m_idx, m_total}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'({m_valid, m_busy, m_done}), 64'd0);
        launch(1'b0, 8'hC3, 2'd1);
        collect(100, 1'b0);
        compare_run("run6", 8'hC3, 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
